// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC/imem req-ack handshake, 2-entry decode queue, redirect squash.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 24,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              redirect_in,
  input  logic              hazard_stall_in,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid,
  output logic              stall_f_out,
  output logic [15:0]       stall_count,
  output logic              fetch_error
);

  localparam int unsigned CNT_W = 2;

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [DATA_W-1:0]  q1;
  logic [ADDR_W-1:0]  addr_q;
  logic               accept, consume, issue;

  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be at least 1");
  end

  // Queue occupancy bookkeeping shared by FSM and queue update
  always_comb begin
    accept    = mem_ack & ~redirect_in & (state == REQ);
    consume   = instr_valid & ~hazard_stall_in;
    count_nxt = count + CNT_W'(accept) - CNT_W'(consume);
    issue     = (count_nxt <= CNT_W'(1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state and request outputs; DISCARD holds the squashed address until its ack drains
  always_comb begin
    state_nxt   = state;
    mem_req     = 1'b0;
    mem_addr    = pc_in;
    stall_f_out = ~(accept | redirect_in);
    case (state)
      IDLE: begin
        if (issue && !redirect_in) state_nxt = REQ;
      end
      REQ: begin
        mem_req = 1'b1;
        if (redirect_in)  state_nxt = mem_ack ? IDLE : DISCARD;
        else if (accept)  state_nxt = issue ? REQ : IDLE;
      end
      DISCARD: begin
        mem_req  = 1'b1;
        mem_addr = addr_q;
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              addr_q <= '0;
    else if (state == REQ)  addr_q <= pc_in;
  end

  // In-order 2-entry queue: instr_out is the head, q1 the second entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count       <= '0;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      q1          <= '0;
    end else if (redirect_in) begin
      count       <= '0;
      instr_valid <= 1'b0;
    end else begin
      count       <= count_nxt;
      instr_valid <= (count_nxt != '0);
      if (consume) begin
        instr_out <= (accept && count == CNT_W'(1)) ? mem_rdata : q1;
        if (accept && count == CNT_W'(2)) q1 <= mem_rdata;
      end else if (accept) begin
        if (count == '0) instr_out <= mem_rdata;
        else             q1        <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                    stall_count <= '0;
    else if (stall_f_out && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYC + 1);

  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  always_comb waiting = ((state == REQ) || (state == DISCARD)) && !mem_ack;

  // Counts consecutive unanswered request cycles; error is sticky until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      fetch_error <= 1'b0;
    end else if (waiting) begin
      if (wait_cnt != WAIT_W'(TIMEOUT_CYC)) wait_cnt <= wait_cnt + WAIT_W'(1);
      if (wait_cnt == WAIT_W'(TIMEOUT_CYC - 1)) fetch_error <= 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; the bench models the PC register and
// instruction memory (rdata = address) and checks hand-computed values each cycle.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] pc_in;
  logic        redirect_in;
  logic        hazard_stall_in;
  logic        mem_req;
  logic [23:0] mem_addr;
  logic        mem_ack;
  logic [23:0] mem_rdata;
  logic [23:0] instr_out;
  logic        instr_valid;
  logic        stall_f_out;
  logic [15:0] stall_count;
  logic        fetch_error;

  logic [23:0] pc_init;
  logic [23:0] target;
  int          checks = 0;
  int          errors = 0;

  fetch_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .pc_in          (pc_in),
    .redirect_in    (redirect_in),
    .hazard_stall_in(hazard_stall_in),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_out      (instr_out),
    .instr_valid    (instr_valid),
    .stall_f_out    (stall_f_out),
    .stall_count    (stall_count),
    .fetch_error    (fetch_error)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem_addr;

  // PC register: enable is ~stall_f_out, redirect loads the target
  always_ff @(posedge clk or posedge reset) begin
    if (reset)             pc_in <= pc_init;
    else if (redirect_in)  pc_in <= target;
    else if (!stall_f_out) pc_in <= pc_in + 24'd4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic [23:0] pc0);
    reset           = 1'b1;
    mem_ack         = 1'b0;
    redirect_in     = 1'b0;
    hazard_stall_in = 1'b0;
    target          = '0;
    pc_init         = pc0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    reset = 1'b1; mem_ack = 1'b0; redirect_in = 1'b0; hazard_stall_in = 1'b0;
    pc_init = '0; target = '0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_mem_req",     32'(mem_req),     32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr_out",   32'(instr_out),   32'd0);
    check("rst_stall_f",     32'(stall_f_out), 32'd1);
    check("rst_stall_count", 32'(stall_count), 32'd0);
    check("rst_fetch_error", 32'(fetch_error), 32'd0);

    // 1: ack every cycle, back-to-back fetch
    start(24'h0);
    mem_ack = 1'b1; #1;
    check("t1_c0_mem_req", 32'(mem_req), 32'd0);
    check("t1_c0_stall",   32'(stall_f_out), 32'd1);
    tick(); #1;
    check("t1_c1_mem_req",  32'(mem_req), 32'd1);
    check("t1_c1_mem_addr", 32'(mem_addr), 32'h0);
    check("t1_c1_stall",    32'(stall_f_out), 32'd0);
    tick(); #1;
    check("t1_c2_valid", 32'(instr_valid), 32'd1);
    check("t1_c2_instr", 32'(instr_out), 32'h0);
    check("t1_c2_addr",  32'(mem_addr), 32'h4);
    tick(); #1;
    check("t1_c3_instr",       32'(instr_out), 32'h4);
    check("t1_c3_stall_count", 32'(stall_count), 32'd1);

    // 2: ack on the third REQ cycle of each word
    start(24'h0);
    #1;
    for (int w = 0; w < 3; w++) begin
      tick(); mem_ack = 1'b0; #1;
      check("t2_stall_count", 32'(stall_count), 32'(1 + 2 * w));
      check("t2_addr",        32'(mem_addr), 32'(4 * w));
      check("t2_wait_stall",  32'(stall_f_out), 32'd1);
      tick(); #1;
      check("t2_wait2_stall", 32'(stall_f_out), 32'd1);
      tick(); mem_ack = 1'b1; #1;
      check("t2_ack_stall",   32'(stall_f_out), 32'd0);
    end
    tick(); mem_ack = 1'b0; #1;
    check("t2_final_count", 32'(stall_count), 32'd7);
    check("t2_final_instr", 32'(instr_out), 32'h8);

    // 3: redirect one cycle into a pending fetch of 0x10, with 0xC held in the queue
    start(24'h00000C);
    #1;
    check("t3_c0_mem_req", 32'(mem_req), 32'd0);
    tick(); mem_ack = 1'b1; hazard_stall_in = 1'b1; #1;
    check("t3_c1_addr", 32'(mem_addr), 32'hC);
    tick(); mem_ack = 1'b0; #1;
    check("t3_c2_valid", 32'(instr_valid), 32'd1);
    check("t3_c2_instr", 32'(instr_out), 32'hC);
    check("t3_c2_addr",  32'(mem_addr), 32'h10);
    tick(); redirect_in = 1'b1; target = 24'h000100; #1;
    check("t3_c3_stall", 32'(stall_f_out), 32'd0);
    tick(); redirect_in = 1'b0; hazard_stall_in = 1'b0; #1;
    check("t3_c4_mem_req", 32'(mem_req), 32'd1);
    check("t3_c4_addr",    32'(mem_addr), 32'h10);
    check("t3_c4_valid",   32'(instr_valid), 32'd0);
    check("t3_c4_stall",   32'(stall_f_out), 32'd1);
    tick(); mem_ack = 1'b1; #1;
    check("t3_c5_addr",  32'(mem_addr), 32'h10);
    check("t3_c5_stall", 32'(stall_f_out), 32'd1);
    tick(); mem_ack = 1'b0; #1;
    check("t3_c6_mem_req", 32'(mem_req), 32'd0);
    check("t3_c6_valid",   32'(instr_valid), 32'd0);
    tick(); mem_ack = 1'b1; #1;
    check("t3_c7_mem_req", 32'(mem_req), 32'd1);
    check("t3_c7_addr",    32'(mem_addr), 32'h100);
    tick(); mem_ack = 1'b0; #1;
    check("t3_c8_valid", 32'(instr_valid), 32'd1);
    check("t3_c8_instr", 32'(instr_out), 32'h100);

    // 4: redirect coincident with ack; ack in IDLE ignored
    start(24'h0);
    #1;
    tick(); mem_ack = 1'b1; redirect_in = 1'b1; target = 24'h000200; #1;
    check("t4_c1_stall",   32'(stall_f_out), 32'd0);
    check("t4_c1_mem_req", 32'(mem_req), 32'd1);
    tick(); redirect_in = 1'b0; #1;
    check("t4_c2_valid",   32'(instr_valid), 32'd0);
    check("t4_c2_mem_req", 32'(mem_req), 32'd0);
    check("t4_c2_stall",   32'(stall_f_out), 32'd1);
    tick(); mem_ack = 1'b0; #1;
    check("t4_c3_mem_req", 32'(mem_req), 32'd1);
    check("t4_c3_addr",    32'(mem_addr), 32'h200);

    // 5: decode stalled five cycles with ack every cycle
    start(24'h0);
    hazard_stall_in = 1'b1; mem_ack = 1'b1; #1;
    check("t5_c0_mem_req", 32'(mem_req), 32'd0);
    tick(); #1;
    check("t5_c1_addr",  32'(mem_addr), 32'h0);
    check("t5_c1_stall", 32'(stall_f_out), 32'd0);
    tick(); #1;
    check("t5_c2_instr",   32'(instr_out), 32'h0);
    check("t5_c2_addr",    32'(mem_addr), 32'h4);
    check("t5_c2_mem_req", 32'(mem_req), 32'd1);
    tick(); #1;
    check("t5_c3_mem_req", 32'(mem_req), 32'd0);
    check("t5_c3_instr",   32'(instr_out), 32'h0);
    check("t5_c3_stall",   32'(stall_f_out), 32'd1);
    tick(); #1;
    check("t5_c4_mem_req", 32'(mem_req), 32'd0);
    check("t5_c4_instr",   32'(instr_out), 32'h0);
    tick(); hazard_stall_in = 1'b0; #1;
    check("t5_c5_instr",   32'(instr_out), 32'h0);
    check("t5_c5_valid",   32'(instr_valid), 32'd1);
    check("t5_c5_mem_req", 32'(mem_req), 32'd0);
    tick(); #1;
    check("t5_c6_instr", 32'(instr_out), 32'h4);
    check("t5_c6_addr",  32'(mem_addr), 32'h8);
    tick(); #1;
    check("t5_c7_instr", 32'(instr_out), 32'h8);
    check("t5_c7_addr",  32'(mem_addr), 32'hC);
    tick(); #1;
    check("t5_c8_instr", 32'(instr_out), 32'hC);

    // 6: ack withheld; watchdog fires after 16 wait cycles when enabled
    start(24'h0);
    #1;
    repeat (16) tick();
    #1;
    check("t6_c16_error", 32'(fetch_error), 32'd0);
    tick(); mem_ack = 1'b1; #1;
`ifdef FETCH_TIMEOUT_EN
    check("t6_c17_error", 32'(fetch_error), 32'd1);
`else
    check("t6_c17_error", 32'(fetch_error), 32'd0);
`endif
    tick(); mem_ack = 1'b0; #1;
`ifdef FETCH_TIMEOUT_EN
    check("t6_sticky_error", 32'(fetch_error), 32'd1);
`else
    check("t6_sticky_error", 32'(fetch_error), 32'd0);
`endif
    start(24'h0);
    #1;
    check("t6_error_after_reset", 32'(fetch_error), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
